// File: rtl/mips_run_controller_pkg.sv
// Shared opcodes, widths and state encodings for the MIPS debug/run sequencer.
package mips_run_controller_pkg;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_RUN     = 3'd1,
    CMD_STEP    = 3'd2,
    CMD_HALT    = 3'd3,
    CMD_RD_REG  = 3'd4,
    CMD_RD_MEM  = 3'd5,
    CMD_RD_CYC  = 3'd6,
    CMD_CPU_RST = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_STEP     = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_SRST     = 3'd4,
    S_RESP     = 3'd5
  } state_e;
endpackage

// File: rtl/mips_run_controller.sv
// Debug/run sequencer: gates the pipeline enable, issues soft reset, counts cycles
// and serves host reads of the register bank and data memory.
module mips_run_controller
  import mips_run_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  cpu_enable,
  output logic                  cpu_soft_reset,
  input  logic                  cpu_halt,
  output logic                  halted,
  output logic [4:0]            dbg_reg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_reg_data,
  output logic                  dbg_mem_sel,
  output logic [ADDR_WIDTH-1:0] dbg_mem_addr,
  input  logic [DATA_WIDTH-1:0] dbg_mem_rdata
);
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e          state, ret_state;
  logic [31:0]     cycle_cnt;
  logic [RCW-1:0]  rst_cnt;
  logic            rd_mem, mem_phase;
  cmd_e            op;

  assign op = cmd_e'(cmd_op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      ret_state      <= S_IDLE;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      cpu_enable     <= 1'b0;
      cpu_soft_reset <= 1'b0;
      halted         <= 1'b0;
      dbg_reg_addr   <= '0;
      dbg_mem_sel    <= 1'b0;
      dbg_mem_addr   <= '0;
      cycle_cnt      <= '0;
      rst_cnt        <= '0;
      rd_mem         <= 1'b0;
      mem_phase      <= 1'b0;
    end else begin
      if (cpu_enable) cycle_cnt <= cycle_cnt + 32'd1;
      // Retired halt stops the pipeline wherever we are; later branches refine the state.
      if (cpu_enable && cpu_halt) begin
        halted     <= 1'b1;
        cpu_enable <= 1'b0;
        ret_state  <= S_IDLE;
      end

      case (state)
        S_IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
          rsp_err   <= 1'b0;
          ret_state <= S_IDLE;
          state     <= S_RESP;
          case (op)
            CMD_RUN: begin
              if (halted) rsp_err <= 1'b1;
              else begin
                cpu_enable <= 1'b1;
                ret_state  <= S_RUN;
              end
            end
            CMD_STEP: begin
              if (halted) rsp_err <= 1'b1;
              else begin
                cpu_enable <= 1'b1;
                rsp_valid  <= 1'b0;
                state      <= S_STEP;
              end
            end
            CMD_RD_REG: begin
              dbg_reg_addr <= cmd_addr[4:0];
              rd_mem       <= 1'b0;
              rsp_valid    <= 1'b0;
              state        <= S_MEM_WAIT;
            end
            CMD_RD_MEM: begin
              dbg_mem_sel  <= 1'b1;
              dbg_mem_addr <= cmd_addr & ~ADDR_WIDTH'(3);
              rd_mem       <= 1'b1;
              mem_phase    <= 1'b0;
              rsp_valid    <= 1'b0;
              state        <= S_MEM_WAIT;
            end
            CMD_RD_CYC: rsp_data <= DATA_WIDTH'(cycle_cnt);
            CMD_CPU_RST: begin
              cpu_enable     <= 1'b0;
              cpu_soft_reset <= 1'b1;
              rst_cnt        <= RCW'(RST_CYCLES - 1);
              cycle_cnt      <= '0;
              halted         <= 1'b0;
              rsp_valid      <= 1'b0;
              state          <= S_SRST;
            end
            CMD_NOP, CMD_HALT: ;
          endcase
        end else if (cpu_enable && cpu_halt) begin
          state <= S_IDLE;
        end

        S_RUN: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
          rsp_err   <= 1'b0;
          ret_state <= cpu_halt ? S_IDLE : S_RUN;
          state     <= S_RESP;
          case (op)
            CMD_NOP:    ;
            CMD_HALT: begin
              cpu_enable <= 1'b0;
              ret_state  <= S_IDLE;
            end
            CMD_RD_CYC: rsp_data <= DATA_WIDTH'(cycle_cnt);
            CMD_CPU_RST: begin
              cpu_enable     <= 1'b0;
              cpu_soft_reset <= 1'b1;
              rst_cnt        <= RCW'(RST_CYCLES - 1);
              cycle_cnt      <= '0;
              halted         <= 1'b0;
              rsp_valid      <= 1'b0;
              state          <= S_SRST;
            end
            default:    rsp_err <= 1'b1;
          endcase
        end else if (cpu_halt) begin
          state <= S_IDLE;
        end

        S_STEP: begin
          cpu_enable <= 1'b0;
          rsp_valid  <= 1'b1;
          ret_state  <= S_IDLE;
          state      <= S_RESP;
        end

        // Register bank reads are combinational; memory needs sel for one cycle then a data cycle.
        S_MEM_WAIT: begin
          if (!rd_mem) begin
            rsp_data  <= dbg_reg_data;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (!mem_phase) begin
            dbg_mem_sel <= 1'b0;
            mem_phase   <= 1'b1;
          end else begin
            rsp_data  <= dbg_mem_rdata;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end

        S_SRST: begin
          if (rst_cnt == '0) begin
            cpu_soft_reset <= 1'b0;
            rsp_valid      <= 1'b1;
            ret_state      <= S_IDLE;
            state          <= S_RESP;
          end else begin
            rst_cnt <= rst_cnt - RCW'(1);
          end
        end

        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= (cpu_enable && cpu_halt) ? S_IDLE : ret_state;
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
